// File: rtl/fifo_burst_rd_sched.sv
// fifo_burst_rd_sched: bursts reads out of the async FIFO read port and re-times them onto a valid/ready stream
module fifo_burst_rd_sched #(
  parameter int DATA_WIDTH  = 11,
  parameter int DEPTH_WIDTH = 13,
  parameter int BURST_LEN   = 256,
  parameter int RD_LATENCY  = 1,
  parameter int OBUF_DEPTH  = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   fifo_rd_en,
  input  logic                   fifo_rd_empty,
  input  logic [DEPTH_WIDTH:0]   fifo_rd_water_level,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   partial
);
  localparam int LW = DEPTH_WIDTH + 1;
  localparam int CW = $clog2(OBUF_DEPTH + 1);
  localparam int AW = OBUF_DEPTH > 1 ? $clog2(OBUF_DEPTH) : 1;
  localparam int IW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  state_t state, state_n;
  logic [LW-1:0] rem, rem_n;
  logic [IW-1:0] idle_cnt, idle_cnt_n;
  logic [CW-1:0] occ, inflight;
  logic [AW-1:0] wp, rp;
  logic [DATA_WIDTH-1:0] mem [OBUF_DEPTH];
  logic [OBUF_DEPTH-1:0] tag;
  logic [RD_LATENCY-1:0] vp, tp;
  logic level_nz, full_go, part_go, go, credit, wr, rd;

  assign level_nz = |fifo_rd_water_level;
  assign full_go  = en & (fifo_rd_water_level >= LW'(BURST_LEN));
  assign part_go  = (TIMEOUT != 0) & en & level_nz & (idle_cnt == IDLE_MAX);
  // Issued-but-unwritten reads reserve buffer space so the buffer can never overflow
  assign credit   = ({1'b0, occ} + {1'b0, inflight}) < (CW + 1)'(OBUF_DEPTH);
  assign wr       = vp[RD_LATENCY-1];
  assign rd       = out_valid & out_ready;
  assign out_valid = occ != '0;
  assign out_data  = out_valid ? mem[rp] : '0;
  assign out_last  = out_valid & tag[rp];

  always_comb begin
    go = (state == IDLE) & (full_go | part_go);
    partial = go & ~full_go;
    busy = state != IDLE;
    fifo_rd_en = (state == BURST) & (rem != '0) & ~fifo_rd_empty & credit;
    rem_n = go ? (full_go ? LW'(BURST_LEN) : fifo_rd_water_level) : rem - LW'(fifo_rd_en);
    idle_cnt_n = ((state == IDLE) & en & level_nz & ~go) ? idle_cnt + IW'(idle_cnt != IDLE_MAX) : '0;
    state_n = state;
    case (state)
      IDLE:    state_n = go ? BURST : IDLE;
      BURST:   state_n = rem_n == '0 ? DRAIN : BURST;
      DRAIN:   state_n = (inflight == '0 && occ == '0) ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rem <= '0;
      idle_cnt <= '0;
      occ <= '0;
      inflight <= '0;
      wp <= '0;
      rp <= '0;
      vp <= '0;
      tp <= '0;
    end else begin
      state <= state_n;
      rem <= rem_n;
      idle_cnt <= idle_cnt_n;
      occ <= occ + CW'(wr) - CW'(rd);
      inflight <= inflight + CW'(fifo_rd_en) - CW'(wr);
      vp <= (vp << 1) | RD_LATENCY'(fifo_rd_en);
      tp <= (tp << 1) | RD_LATENCY'(rem == LW'(1));
      if (wr) wp <= wp == AW'(OBUF_DEPTH - 1) ? '0 : wp + AW'(1);
      if (rd) rp <= rp == AW'(OBUF_DEPTH - 1) ? '0 : rp + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wp] <= fifo_rd_data;
      tag[wp] <= tp[RD_LATENCY-1];
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(wr && !rd && occ == CW'(OBUF_DEPTH)));
endmodule

// File: tb/tb_fifo_burst_rd_sched.sv
// tb_fifo_burst_rd_sched: scoreboard bench driving RD_LATENCY=1 and RD_LATENCY=2 instances in lockstep
module tb_fifo_burst_rd_sched;
  localparam int DW = 11;
  localparam int LW = 14;

  logic clk = 0, rst = 0, en = 0, out_ready = 1;
  logic rd_en0, rd_en1, empty0, empty1, valid0, valid1, last0, last1, busy0, busy1, part0, part1;
  logic [LW-1:0] level0, level1;
  logic [DW-1:0] rdata0, rdata1, odata0, odata1, st1;
  logic [DW-1:0] fq0[$], fq1[$];
  logic [DW:0] exp0[$], exp1[$];
  logic force_empty = 0, tog = 0, bl0, bl1;
  int total = 0, bad = 0, cyc = 0, widx = 0, eidx = 0;
  int rds0, rds1, xf0, xf1, lasts0, lasts1, parts0, parts1, mo0, mo1;
  int rd_first0, rd_last0, tx0, tx1, tf0, tf1, tpart, t0, n, nb;

  always #5 clk = ~clk;

  fifo_burst_rd_sched u0 (
    .clk(clk), .rst(rst), .en(en), .fifo_rd_en(rd_en0), .fifo_rd_empty(empty0),
    .fifo_rd_water_level(level0), .fifo_rd_data(rdata0), .out_data(odata0), .out_valid(valid0),
    .out_ready(out_ready), .out_last(last0), .busy(busy0), .partial(part0)
  );

  fifo_burst_rd_sched #(.RD_LATENCY(2)) u1 (
    .clk(clk), .rst(rst), .en(en), .fifo_rd_en(rd_en1), .fifo_rd_empty(empty1),
    .fifo_rd_water_level(level1), .fifo_rd_data(rdata1), .out_data(odata1), .out_valid(valid1),
    .out_ready(out_ready), .out_last(last1), .busy(busy1), .partial(part1)
  );

  task automatic chk(string tg, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tg, got, want);
    end
  endtask

  function automatic logic [DW-1:0] word(int k);
    return DW'(k * 37 + 5);
  endfunction

  task automatic upd();
    level0 = LW'(fq0.size());
    level1 = LW'(fq1.size());
    empty0 = force_empty || fq0.size() == 0;
    empty1 = force_empty || fq1.size() == 0;
  endtask

  task automatic load(int cnt);
    for (int i = 0; i < cnt; i++) begin
      fq0.push_back(word(widx));
      fq1.push_back(word(widx));
      widx++;
    end
    upd();
  endtask

  task automatic expect_burst(int cnt);
    for (int i = 0; i < cnt; i++) begin
      exp0.push_back({i == cnt - 1, word(eidx)});
      exp1.push_back({i == cnt - 1, word(eidx)});
      eidx++;
    end
  endtask

  task automatic clr();
    rds0 = 0; rds1 = 0; xf0 = 0; xf1 = 0; lasts0 = 0; lasts1 = 0; parts0 = 0; parts1 = 0;
    mo0 = 0; mo1 = 0; rd_first0 = 0; rd_last0 = 0; tx0 = 0; tx1 = 0; tf0 = 0; tf1 = 0;
    tpart = 0; bl0 = 0; bl1 = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    fq0.delete(); fq1.delete(); exp0.delete(); exp1.delete();
    widx = 0; eidx = 0; st1 = '0;
    upd();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    clr();
  endtask

  task automatic step();
    logic [DW:0] e;
    logic pb0, pb1;
    @(negedge clk);
    cyc++;
    if (rd_en0) begin
      if (fq0.size() == 0) chk("rd_while_empty0", 1, 0);
      if (rds0 == 0) rd_first0 = cyc;
      rd_last0 = cyc;
      rds0++;
    end
    if (rd_en1) begin
      if (fq1.size() == 0) chk("rd_while_empty1", 1, 0);
      rds1++;
    end
    if (part0) begin parts0++; tpart = cyc; end
    if (part1) parts1++;
    if (!busy0 && bl0) tf0 = cyc;
    if (!busy1 && bl1) tf1 = cyc;
    bl0 = busy0;
    bl1 = busy1;
    if (valid0 && out_ready) begin
      xf0++; tx0 = cyc; lasts0 += int'(last0);
      if (exp0.size() == 0) chk("extra_word0", 1, 0);
      else begin
        e = exp0.pop_front();
        chk("data0", 32'(odata0), 32'(e[DW-1:0]));
        chk("last0", 32'(last0), 32'(e[DW]));
      end
    end
    if (valid1 && out_ready) begin
      xf1++; tx1 = cyc; lasts1 += int'(last1);
      if (exp1.size() == 0) chk("extra_word1", 1, 0);
      else begin
        e = exp1.pop_front();
        chk("data1", 32'(odata1), 32'(e[DW-1:0]));
        chk("last1", 32'(last1), 32'(e[DW]));
      end
    end
    if (rds0 - xf0 > mo0) mo0 = rds0 - xf0;
    if (rds1 - xf1 > mo1) mo1 = rds1 - xf1;
    pb0 = rd_en0;
    pb1 = rd_en1;
    @(posedge clk);
    #1;
    rdata1 = st1;
    if (pb1 && fq1.size() != 0) st1 = fq1.pop_front();
    if (pb0 && fq0.size() != 0) rdata0 = fq0.pop_front();
    if (tog) out_ready = ~out_ready;
    upd();
  endtask

  initial begin
    rdata0 = '0; rdata1 = '0; st1 = '0;
    rst = 1;
    upd();
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out0", 32'({rd_en0, valid0, last0, busy0, part0, odata0}), 0);
    chk("reset_out1", 32'({rd_en1, valid1, last1, busy1, part1, odata1}), 0);
    rst = 0;
    // full burst from level 300
    load(300); expect_burst(256); en = 1;
    repeat (300) step();
    chk("t1_rd0", rds0, 256);
    chk("t1_rd_span0", rd_last0 - rd_first0 + 1, 256);
    chk("t1_xfer0", xf0, 256);
    chk("t1_xfer1", xf1, 256);
    chk("t1_lastcnt0", lasts0, 1);
    chk("t1_lastcnt1", lasts1, 1);
    chk("t1_busy_fall0", tf0 - tx0, 2);
    chk("t1_busy_fall1", tf1 - tx1, 2);
    chk("t1_level", 32'(level0), 44);
    chk("t1_partial", parts0 + parts1, 0);
    chk("t1_sb_left", exp0.size() + exp1.size(), 0);
    // timeout-forced partial burst
    do_reset(); load(10); expect_burst(10);
    t0 = cyc;
    repeat (1100) step();
    chk("t2_partial_cyc", tpart - t0, 1024);
    chk("t2_partial_cnt0", parts0, 1);
    chk("t2_partial_cnt1", parts1, 1);
    chk("t2_xfer0", xf0, 10);
    chk("t2_xfer1", xf1, 10);
    chk("t2_lastcnt0", lasts0, 1);
    chk("t2_level", 32'(level0), 0);
    chk("t2_sb_left", exp0.size() + exp1.size(), 0);
    // backpressure: credit stops issue at buffer depth
    do_reset(); out_ready = 0; load(300); expect_burst(256);
    repeat (40) step();
    chk("t3_rd_stall0", rds0, 4);
    chk("t3_rd_stall1", rds1, 4);
    chk("t3_no_xfer", xf0 + xf1, 0);
    out_ready = 1;
    repeat (300) step();
    chk("t3_rd0", rds0, 256);
    chk("t3_xfer0", xf0, 256);
    chk("t3_xfer1", xf1, 256);
    chk("t3_sb_left", exp0.size() + exp1.size(), 0);
    // toggling ready, level exactly BURST_LEN
    do_reset(); load(256); expect_burst(256); tog = 1;
    repeat (700) step();
    tog = 0; out_ready = 1;
    chk("t4_occ_ok0", 32'(mo0 <= 4), 1);
    chk("t4_occ_ok1", 32'(mo1 <= 4), 1);
    chk("t4_xfer0", xf0, 256);
    chk("t4_xfer1", xf1, 256);
    chk("t4_lastcnt1", lasts1, 1);
    chk("t4_partial", parts0 + parts1, 0);
    chk("t4_sb_left", exp0.size() + exp1.size(), 0);
    // FIFO empty for 20 cycles after word 100
    do_reset(); load(300); expect_burst(256);
    for (int i = 0; i < 300 && rds0 < 100; i++) step();
    chk("t5_reach100", rds0, 100);
    force_empty = 1; upd();
    n = rds0 + rds1; nb = 0;
    repeat (20) begin
      step();
      nb += int'(!busy0) + int'(!busy1);
    end
    chk("t5_rd_in_gap", rds0 + rds1 - n, 0);
    chk("t5_busy_in_gap", nb, 0);
    force_empty = 0; upd();
    repeat (300) step();
    chk("t5_rd0", rds0, 256);
    chk("t5_xfer0", xf0, 256);
    chk("t5_xfer1", xf1, 256);
    chk("t5_sb_left", exp0.size() + exp1.size(), 0);
    // en dropped mid-burst, then async reset mid-burst
    do_reset(); load(600); expect_burst(256);
    for (int i = 0; i < 200 && rds0 < 50; i++) step();
    en = 0;
    repeat (400) step();
    chk("t6_rd0", rds0, 256);
    chk("t6_xfer0", xf0, 256);
    chk("t6_xfer1", xf1, 256);
    chk("t6_idle", 32'({busy0, busy1}), 0);
    chk("t6_level", 32'(level0), 344);
    chk("t6_sb_left", exp0.size() + exp1.size(), 0);
    expect_burst(256); en = 1;
    repeat (30) step();
    chk("t6_busy_pre_rst", 32'({busy0, busy1}), 3);
    rst = 1;
    #1;
    chk("t6_async_rst0", 32'({rd_en0, valid0, last0, busy0, part0, odata0}), 0);
    chk("t6_async_rst1", 32'({rd_en1, valid1, last1, busy1, part1, odata1}), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_burst_rd_sched.md
Name: fifo_burst_rd_sched

Overview:
- Read-side scheduler for the 8192x11 async FIFO. Runs in the rd_clk domain.
- Watches the FIFO read water level and issues rd_en in bursts of BURST_LEN words. A timeout forces a partial burst when data sits below the threshold.
- Re-times FIFO read data through a small credit-checked output buffer onto a valid/ready stream with a last-of-burst marker.
- Sits between the FIFO read port and the downstream packetiser.

Parameters:
- DATA_WIDTH, 11, FIFO read data width.
- DEPTH_WIDTH, 13, FIFO read depth width; the level input is DEPTH_WIDTH+1 bits.
- BURST_LEN, 256, words per full burst; legal 1..2^DEPTH_WIDTH.
- RD_LATENCY, 1, cycles from accepted rd_en to valid fifo_rd_data; legal 1 or 2 (2 when the FIFO output register is on).
- OBUF_DEPTH, 4, output buffer entries; must be >= RD_LATENCY+1.
- TIMEOUT, 1024, idle cycles with non-zero level before a partial burst; 0 disables the timeout.

Ports:
- clk  input  1  read clock, same as FIFO rd_clk.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  scheduler enable, level-sensitive.
- fifo_rd_en  output  1  FIFO read enable.
- fifo_rd_empty  input  1  FIFO empty flag.
- fifo_rd_water_level  input  DEPTH_WIDTH+1  FIFO read water level.
- fifo_rd_data  input  DATA_WIDTH  FIFO read data.
- out_data  output  DATA_WIDTH  stream data.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready.
- out_last  output  1  high on the final word of each burst.
- busy  output  1  high in state BURST or DRAIN.
- partial  output  1  one-cycle pulse when a timeout-forced burst starts.

Behaviour:
- Reset (async assert, released on clk): state=IDLE, all counters 0, buffer empty. fifo_rd_en=0, out_valid=0, out_last=0, out_data=0, busy=0, partial=0.
- States: IDLE, BURST, DRAIN.
- IDLE → BURST, only when en=1:
  - if level >= BURST_LEN: load rem=BURST_LEN.
  - else if TIMEOUT!=0, level!=0 and idle_cnt==TIMEOUT-1: load rem=level and pulse partial.
- idle_cnt rules:
  - counts in IDLE while en=1 and level!=0.
  - clears on any transition out of IDLE, and whenever level==0 or en=0.
  - saturates at TIMEOUT-1.
- BURST:
  - fifo_rd_en = (rem!=0) & !fifo_rd_empty & (occ + inflight < OBUF_DEPTH). This is combinational from registered state plus fifo_rd_empty.
  - Each asserted rd_en decrements rem and increments inflight.
  - Go to DRAIN when rem reaches 0.
- DRAIN: go to IDLE when inflight==0 and occ==0 (burst fully delivered). The earliest next burst decision is in the IDLE cycle.
- Read pipeline: a RD_LATENCY-deep valid shift register tracks issued reads. Data is written into the buffer in the cycle its valid tap exits, independent of later rd_en values.
- inflight counts issued reads not yet written. occ counts buffer entries. The credit check guarantees the buffer never overflows; overflow is a design error and is asserted in simulation.
- Output buffer: FIFO-ordered. out_valid = (occ!=0). out_data is the head entry. Transfer happens on out_valid & out_ready. Back-to-back transfers sustain 1 word/cycle when out_ready is held high.
- out_last: each word carries a tag equal to (its issue index == burst length-1). out_last = head tag & out_valid.
- Simultaneous write and read of the buffer in one cycle: occ is unchanged.
- fifo_rd_empty rising mid-burst: rd_en stalls and the burst resumes when data arrives. There is no burst timeout inside BURST.
- en deasserted mid-burst: the current burst completes (BURST→DRAIN→IDLE). No new burst starts while en=0.
- Level arithmetic: compare the unsigned DEPTH_WIDTH+1-bit level against BURST_LEN. Partial rem = level, which is < BURST_LEN, so rem is DEPTH_WIDTH+1 bits wide.
- rst asserted mid-burst: all state is dropped immediately. Words already read from the FIFO are lost; the FIFO must be reset together with this block.

Test Plan:
- Level=300, en=1, out_ready=1, RD_LATENCY=1 → 256 consecutive rd_en. out_valid stays high for 256 words with out_last on word 256 only. busy falls 2 cycles after the last transfer, level=44 remains, partial=0.
- Level=10 held, en=1, TIMEOUT=1024 → partial pulses on the 1024th idle cycle. Exactly 10 words are delivered with out_last on word 10.
- out_ready=0 throughout a burst, OBUF_DEPTH=4 → exactly 4 rd_en issued, then rd_en=0. Releasing out_ready resumes the burst with no word lost or duplicated; check the data sequence against the write order.
- RD_LATENCY=2, out_ready toggling 1,0,1,0 → the buffer never exceeds 4 entries. All 256 words arrive in order, 1 out_last.
- fifo_rd_empty forced high for 20 cycles at word 100 of a burst → rd_en=0 during those cycles and busy stays high. Words 101..256 follow afterwards.
- en dropped at word 50 → the burst finishes at 256 words, then the block stays in IDLE with level >= 256. rst pulsed mid-burst → all outputs return to 0 asynchronously.
